// File: rtl/axi4_stream_pkt_gen_if.sv
// rtl/axi4_stream_pkt_gen_if.sv - AXI4-Stream channel bundle with master/slave views.
interface axi4_stream_if #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1,
   parameter int ID_WIDTH   = 1
) ();
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic [USER_WIDTH-1:0]   tuser;
   logic [DEST_WIDTH-1:0]   tdest;
   logic [ID_WIDTH-1:0]     tid;
   logic                    tvalid;
   logic                    tready;

   modport master (
      output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
      output tready
   );
endinterface

// File: rtl/axi4_stream_pkt_gen.sv
// rtl/axi4_stream_pkt_gen.sv - programmable AXI4-Stream packet source with
// counting payload, inter-packet gap and graceful stop.
module axi4_stream_pkt_gen #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1,
   parameter int ID_WIDTH   = 1,
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic [LEN_WIDTH-1:0] pkt_len_i,
   input  logic [CNT_WIDTH-1:0] pkt_num_i,
   input  logic [LEN_WIDTH-1:0] gap_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_WIDTH-1:0] pkt_cnt_o,
   axi4_stream_if.master        pkt_o
);
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t                state_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  gap_q;
   logic [LEN_WIDTH-1:0]  beat_q;
   logic [LEN_WIDTH-1:0]  gap_cnt_q;
   logic [CNT_WIDTH-1:0]  num_q;
   logic [CNT_WIDTH-1:0]  pkt_idx_q;
   logic [DATA_WIDTH-1:0] word_q;
   logic                  valid_q;
   logic                  stop_pend_q;

   logic hs;
   logic is_last;
   logic stop_now;
   logic run_done;

   assign hs       = valid_q && pkt_o.tready;
   assign is_last  = (beat_q == len_q - LEN_WIDTH'(1));
   // A stop arriving on the tlast beat itself still ends the run there.
   assign stop_now = stop_pend_q || stop_i;
   assign run_done = (num_q != '0) && (pkt_idx_q + CNT_WIDTH'(1) == num_q);

   // Payload is a pure function of registered state, so it stays stable under backpressure.
   assign pkt_o.tvalid = valid_q;
   assign pkt_o.tdata  = word_q;
   assign pkt_o.tstrb  = '1;
   assign pkt_o.tkeep  = '1;
   assign pkt_o.tlast  = valid_q && is_last;
   assign pkt_o.tuser  = USER_WIDTH'(valid_q && (beat_q == '0));
   assign pkt_o.tdest  = '0;
   assign pkt_o.tid    = ID_WIDTH'(pkt_idx_q);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         len_q       <= '0;
         gap_q       <= '0;
         beat_q      <= '0;
         gap_cnt_q   <= '0;
         num_q       <= '0;
         pkt_idx_q   <= '0;
         word_q      <= '0;
         valid_q     <= 1'b0;
         stop_pend_q <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pkt_cnt_o   <= '0;
      end else begin
         done_o <= 1'b0;
         if (stop_i && state_q != IDLE) stop_pend_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (start_i) begin
                  len_q       <= (pkt_len_i == '0) ? LEN_WIDTH'(1) : pkt_len_i;
                  num_q       <= pkt_num_i;
                  gap_q       <= gap_i;
                  beat_q      <= '0;
                  word_q      <= '0;
                  pkt_idx_q   <= '0;
                  pkt_cnt_o   <= '0;
                  stop_pend_q <= 1'b0;
                  valid_q     <= 1'b1;
                  busy_o      <= 1'b1;
                  state_q     <= SEND;
               end
            end

            SEND: begin
               if (hs) begin
                  word_q <= word_q + DATA_WIDTH'(1);
                  if (is_last) begin
                     beat_q <= '0;
                     if (pkt_cnt_o != '1) pkt_cnt_o <= pkt_cnt_o + CNT_WIDTH'(1);
                     if (run_done || stop_now) begin
                        state_q     <= IDLE;
                        valid_q     <= 1'b0;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        stop_pend_q <= 1'b0;
                     end else begin
                        pkt_idx_q <= pkt_idx_q + CNT_WIDTH'(1);
                        if (gap_q != '0) begin
                           state_q   <= GAP;
                           valid_q   <= 1'b0;
                           gap_cnt_q <= '0;
                        end
                     end
                  end else begin
                     beat_q <= beat_q + LEN_WIDTH'(1);
                  end
               end
            end

            GAP: begin
               if (stop_now) begin
                  state_q     <= IDLE;
                  busy_o      <= 1'b0;
                  done_o      <= 1'b1;
                  stop_pend_q <= 1'b0;
               end else if (gap_cnt_q == gap_q - LEN_WIDTH'(1)) begin
                  state_q <= SEND;
                  valid_q <= 1'b1;
               end else begin
                  gap_cnt_q <= gap_cnt_q + LEN_WIDTH'(1);
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_stream_pkt_gen.sv
// tb/tb_axi4_stream_pkt_gen.sv - directed self-checking bench for axi4_stream_pkt_gen.
module tb_axi4_stream_pkt_gen;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic [15:0] len;
   logic [15:0] num;
   logic [15:0] gap;
   logic        busy;
   logic        done;
   logic [15:0] cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) s_if ();

   axi4_stream_pkt_gen #(
      .DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1),
      .LEN_WIDTH(16), .CNT_WIDTH(16)
   ) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .start_i   (start),
      .stop_i    (stop),
      .pkt_len_i (len),
      .pkt_num_i (num),
      .gap_i     (gap),
      .busy_o    (busy),
      .done_o    (done),
      .pkt_cnt_o (cnt),
      .pkt_o     (s_if)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int pat [12] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1};

   initial begin
      int w;
      int exp_word;
      int cyc;
      logic prev_stall;
      logic [31:0] prev_data;
      logic prev_last;

      rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      len = '0; num = '0; gap = '0; s_if.tready = 1'b0;
      tick(); tick();
      chk("rst_tvalid", s_if.tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_tdata", s_if.tdata, 0);
      chk("rst_tlast", s_if.tlast, 0);
      rst_n = 1'b1; s_if.tready = 1'b1;
      tick();

      // basic run; inputs changed after start must be ignored
      len = 16'd4; num = 16'd2; gap = 16'd0; start = 1'b1;
      tick();
      start = 1'b0; len = 16'd9; num = 16'd5;
      chk("t1_tkeep", s_if.tkeep, 32'hf);
      chk("t1_tstrb", s_if.tstrb, 32'hf);
      chk("t1_tdest", s_if.tdest, 0);
      for (int i = 0; i < 8; i++) begin
         chk("t1_tvalid", s_if.tvalid, 1);
         chk("t1_tdata", s_if.tdata, i);
         chk("t1_tlast", s_if.tlast, (i % 4) == 3);
         chk("t1_tuser", s_if.tuser, (i % 4) == 0);
         chk("t1_tid", s_if.tid, (i / 4) % 2);
         chk("t1_busy", busy, 1);
         tick();
      end
      chk("t1_done", done, 1);
      chk("t1_busy_low", busy, 0);
      chk("t1_tvalid_low", s_if.tvalid, 0);
      chk("t1_cnt", cnt, 2);
      tick();
      chk("t1_done_pulse", done, 0);

      // stop in IDLE is ignored, then a gapped run
      stop = 1'b1; tick(); stop = 1'b0;
      chk("t2_idle_stop", busy, 0);
      len = 16'd2; num = 16'd3; gap = 16'd3; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t2_cnt_clear", cnt, 0);
      w = 0;
      for (int c = 0; c < 12; c++) begin
         chk("t2_tvalid", s_if.tvalid, pat[c]);
         if (s_if.tvalid) begin
            chk("t2_tdata", s_if.tdata, w);
            w++;
         end
         tick();
      end
      chk("t2_done", done, 1);
      chk("t2_cnt", cnt, 3);
      chk("t2_words", w, 6);
      for (int c = 0; c < 3; c++) begin
         chk("t2_after_tvalid", s_if.tvalid, 0);
         tick();
      end

      // backpressure
      len = 16'd5; num = 16'd1; gap = 16'd0; s_if.tready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      exp_word = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      while (!done && cyc < 200) begin
         if (prev_stall) begin
            chk("t3_hold_tdata", s_if.tdata, prev_data);
            chk("t3_hold_tlast", s_if.tlast, prev_last);
         end
         chk("t3_tvalid", s_if.tvalid, 1);
         s_if.tready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         if (s_if.tvalid && s_if.tready) begin
            chk("t3_tdata", s_if.tdata, exp_word);
            chk("t3_tlast", s_if.tlast, exp_word == 4);
            exp_word++;
         end
         prev_stall = s_if.tvalid && !s_if.tready;
         prev_data  = s_if.tdata;
         prev_last  = s_if.tlast;
         tick();
         cyc++;
      end
      chk("t3_done_in_time", done, 1);
      chk("t3_words", exp_word, 5);
      chk("t3_cnt", cnt, 1);
      s_if.tready = 1'b1;
      tick();

      // continuous run stopped during word 1 of packet index 2
      len = 16'd3; num = 16'd0; gap = 16'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("t4_tvalid", s_if.tvalid, 1);
         chk("t4_tdata", s_if.tdata, i);
         tick();
      end
      chk("t4_tdata7", s_if.tdata, 7);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t4_tdata8", s_if.tdata, 8);
      chk("t4_tlast8", s_if.tlast, 1);
      chk("t4_tvalid8", s_if.tvalid, 1);
      tick();
      chk("t4_done", done, 1);
      chk("t4_tvalid_low", s_if.tvalid, 0);
      chk("t4_busy_low", busy, 0);
      chk("t4_cnt", cnt, 3);
      tick();
      chk("t4_no_pkt3", s_if.tvalid, 0);
      chk("t4_done_pulse", done, 0);

      // pkt_len 0 and 1 both give single-word packets
      for (int k = 0; k < 2; k++) begin
         len = 16'(k); num = 16'd4; start = 1'b1;
         tick();
         start = 1'b0;
         for (int i = 0; i < 4; i++) begin
            chk("t5_tvalid", s_if.tvalid, 1);
            chk("t5_tlast", s_if.tlast, 1);
            chk("t5_tuser", s_if.tuser, 1);
            chk("t5_tdata", s_if.tdata, i);
            tick();
         end
         chk("t5_done", done, 1);
         chk("t5_cnt", cnt, 4);
         tick();
      end

      // reset mid-packet, with start held high during reset
      len = 16'd8; num = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_tdata0", s_if.tdata, 0);
      tick();
      chk("t6_tdata1", s_if.tdata, 1);
      tick();
      chk("t6_tdata2", s_if.tdata, 2);
      rst_n = 1'b0; start = 1'b1; len = 16'd1;
      tick();
      chk("t6_tvalid", s_if.tvalid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_cnt", cnt, 0);
      chk("t6_tdata", s_if.tdata, 0);
      chk("t6_done", done, 0);
      rst_n = 1'b1; start = 1'b0;
      tick();
      chk("t6_start_ignored", s_if.tvalid, 0);
      chk("t6_busy_after", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
